// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : Load/store alignment stage between execute and synchronous D-memory.
//            Define DMEM_ACCESS_STATS_EN to add load/store/fault counters.
// Revision : 1.0
// ============================================================================
module dmem_access_unit #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [31:0]       req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_fault_o,
   output logic              d_mem_csn_o,
   output logic              d_mem_wen_o,
   output logic [ADDR_W-1:0] d_mem_addr_o,
   output logic [3:0]        d_mem_be_o,
   output logic [31:0]       d_mem_dout_o,
`ifdef DMEM_ACCESS_STATS_EN
   output logic [31:0]       load_cnt_o,
   output logic [31:0]       store_cnt_o,
   output logic [31:0]       fault_cnt_o,
`endif
   input  logic [31:0]       d_mem_di_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LATENCY - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [2:0]          f3_q, f3_d;
   logic [1:0]          off_q, off_d;
   logic [3:0]          be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         dout_q, dout_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                fault_q, fault_d;

   logic                w_illegal;
   logic                w_misal;
   logic [3:0]          w_be;
   logic [31:0]         w_dout;
   logic [31:0]         w_shift;
   logic [31:0]         w_ext;
   logic                w_unused_addr;

   assign w_unused_addr = ^req_addr_i[31:ADDR_W+2];

   // Request decode: legality, byte lanes and replicated store data.
   always_comb begin
      w_illegal = 1'b0;
      w_misal   = 1'b0;
      w_be      = 4'b1111;
      w_dout    = req_wdata_i;
      if (req_we_i)
         w_illegal = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
      else
         w_illegal = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
      w_misal = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
      case (req_funct3_i[1:0])
         2'b00: begin
            w_dout = {4{req_wdata_i[7:0]}};
            if (req_we_i) w_be = 4'b0001 << req_addr_i[1:0];
         end
         2'b01: begin
            w_dout = {2{req_wdata_i[15:0]}};
            if (req_we_i) w_be = req_addr_i[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_dout = req_wdata_i;
            w_be   = 4'b1111;
         end
      endcase
   end

   assign w_shift = d_mem_di_i >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'd0, w_shift[7:0]};
         3'b101:  w_ext = {16'd0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      be_d    = be_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               we_d  = req_we_i;
               f3_d  = req_funct3_i;
               off_d = req_addr_i[1:0];
               if (w_illegal | w_misal) begin
                  // Faults skip the memory entirely; address/data pins keep old values.
                  fault_d = 1'b1;
                  rdata_d = 32'd0;
                  state_d = S_RESP;
               end else begin
                  addr_d  = req_addr_i[ADDR_W+1:2];
                  be_d    = w_be;
                  if (req_we_i) dout_d = w_dout;
                  cnt_d   = c_LAT_LOAD;
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               rdata_d = we_q ? 32'd0 : w_ext;
               fault_d = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         be_q    <= 4'd0;
         addr_q  <= '0;
         dout_q  <= 32'd0;
         rdata_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign rsp_valid_o  = (state_q == S_RESP);
   assign rsp_rdata_o  = rdata_q;
   assign rsp_fault_o  = fault_q;
   assign d_mem_csn_o  = (state_q != S_ACCESS);
   assign d_mem_wen_o  = ~((state_q == S_ACCESS) & we_q);
   assign d_mem_be_o   = (state_q == S_ACCESS) ? be_q : 4'd0;
   assign d_mem_addr_o = addr_q;
   assign d_mem_dout_o = dout_q;

`ifdef DMEM_ACCESS_STATS_EN
   logic [31:0] load_cnt_q, store_cnt_q, fault_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         load_cnt_q  <= 32'd0;
         store_cnt_q <= 32'd0;
         fault_cnt_q <= 32'd0;
      end else if (state_q == S_RESP) begin
         if (fault_q)   fault_cnt_q <= fault_cnt_q + 32'd1;
         else if (we_q) store_cnt_q <= store_cnt_q + 32'd1;
         else           load_cnt_q  <= load_cnt_q + 32'd1;
      end
   end

   assign load_cnt_o  = load_cnt_q;
   assign store_cnt_o = store_cnt_q;
   assign fault_cnt_o = fault_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory access stage between the multi-cycle core's execute datapath and the synchronous D-memory.
- Accepts one load/store request per handshake and performs byte-lane alignment, byte enables and store-data replication.
- Waits a fixed memory latency, then returns a sign/zero-extended load result or a store completion.
- Flags misaligned or illegal accesses without touching memory; the core's control FSM stalls PC update until RSP_VALID.

Parameters:
MEM_LATENCY, 1, cycles D_MEM_CSN is held low per access; DI is sampled at the end of the last one; legal range 1..15
ADDR_W, 12, D-memory word-address width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
REQ_VALID  input  1  request present
REQ_READY  output  1  unit can accept a request
REQ_WE  input  1  1 = store, 0 = load
REQ_FUNCT3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
REQ_ADDR  input  32  byte address (ALU result)
REQ_WDATA  input  32  store data (rs2)
RSP_VALID  output  1  one-cycle completion pulse
RSP_RDATA  output  32  extended load data; 0 for stores and faults
RSP_FAULT  output  1  misaligned or illegal funct3; valid with RSP_VALID
D_MEM_CSN  output  1  chip select, active low
D_MEM_WEN  output  1  write enable, active low
D_MEM_ADDR  output  ADDR_W  word address = latched addr[ADDR_W+1:2]
D_MEM_BE  output  4  byte-lane enables
D_MEM_DOUT  output  32  lane-replicated store data
D_MEM_DI  input  32  memory read data

Behaviour:
- Async reset (RST=1), effective immediately:
  - state IDLE; REQ_READY=1; RSP_VALID=0; RSP_RDATA=0; RSP_FAULT=0.
  - D_MEM_CSN=1; D_MEM_WEN=1; D_MEM_BE=0; D_MEM_ADDR=0; D_MEM_DOUT=0.
  - Reset mid-access aborts the access: no response and no further memory cycle.
- FSM has three states: IDLE, ACCESS, RESP.
  - IDLE: REQ_READY=1. On REQ_VALID, latch WE, FUNCT3, ADDR and WDATA.
  - Legal request: IDLE goes to ACCESS with the latency counter loaded to MEM_LATENCY-1.
  - Fault: IDLE goes directly to RESP with the fault latched.
  - ACCESS: D_MEM_CSN=0; D_MEM_WEN=~WE; BE, ADDR and DOUT stable. The counter decrements each cycle. At counter 0, D_MEM_DI is captured (loads only) and the FSM goes to RESP.
  - RESP: RSP_VALID=1 for exactly one cycle, then IDLE. REQ_READY=0 in ACCESS and RESP.
- Latency, with the handshake in cycle 0:
  - ACCESS occupies cycles 1..MEM_LATENCY.
  - RSP_VALID is high in cycle MEM_LATENCY+1.
  - A fault responds in cycle 1.
  - The next request is accepted in the cycle after RESP.
- Fault rules:
  - Illegal funct3: loads with 011/110/111; stores with funct3 ≥ 011.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
  - On fault: no CSN assertion, RSP_FAULT=1, RSP_RDATA=0.
- Store lanes, with o=addr[1:0]:
  - SB: BE=1<<o; DOUT={4{wdata[7:0]}}.
  - SH: BE=0011 (o=0) or 1100 (o=2); DOUT={2{wdata[15:0]}}.
  - SW: BE=1111; DOUT=wdata.
- Loads: BE=1111 during ACCESS. The captured word is shifted right by 8*o, then:
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW passes the word through.
- Outside ACCESS: CSN=1, WEN=1, BE=0. ADDR and DOUT hold their last values.
- RSP_RDATA and RSP_FAULT are registered and hold their value until the next RESP. Their reset value is 0.
- REQ inputs are ignored outside IDLE.

Optional Feature:
- Macro: DMEM_ACCESS_STATS_EN.
- Defined: adds 32-bit outputs LOAD_CNT, STORE_CNT and FAULT_CNT.
  - Each counter increments in the RESP cycle of the matching completion; faults count only in FAULT_CNT.
  - Counters reset to 0 on RST and wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert RST mid-ACCESS (MEM_LATENCY=3) -> CSN=1 and REQ_READY=1 the same cycle; no RSP_VALID follows.
- SB: addr=0x103, wdata=0x000000A5 -> BE=1000, DOUT=0xA5A5A5A5, D_MEM_ADDR=0x040, WEN=0 for MEM_LATENCY cycles, then RSP_VALID with RSP_RDATA=0.
- LB/LBU: DI=0x80FF7F01, addr=0x202 -> LB gives 0xFFFFFFFF, LBU gives 0x000000FF. addr=0x203 -> LB gives 0xFFFFFF80.
- LH/LW: DI=0x8001_7FFE. LH at offset 2 gives 0xFFFF8001; LHU at offset 0 gives 0x00007FFE. LW with MEM_LATENCY=4 -> RSP_VALID exactly 5 cycles after the handshake.
- Faults: LW addr=0x006 and LH addr=0x001 -> CSN never low, RSP_VALID next cycle, RSP_FAULT=1, RSP_RDATA=0. Store funct3=011 -> same response.
- Back-to-back: hold REQ_VALID=1 across a stream of SW, LW -> second handshake exactly one cycle after the first RSP_VALID; the LW returns the stored word.
